song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 195 +++++++++++++++++++
 tb/tb_song_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song ROM sequencer: walks the 32 entries of the selected song, hands note entries
// to the lowest free voice and paces advance entries by counting beat pulses.
module song_reader (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        play,
   input  logic [1:0]  song_sel,
   input  logic        beat,
   output logic [6:0]  rom_addr,
   input  logic [15:0] rom_data,
   input  logic [2:0]  voice_free,
   output logic        new_note,
   output logic [2:0]  voice_load,
   output logic [5:0]  note_out,
   output logic [5:0]  dur_out,
   output logic [2:0]  meta_out,
   output logic        song_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAIT_VOICE,
      S_ADVANCE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t      r_state, w_state;
   logic [4:0]  r_index, w_index;
   logic [5:0]  r_wait, w_wait;
   logic [1:0]  r_song, w_song;
   logic [6:0]  r_rom_addr, w_rom_addr;
   logic        r_new_note, w_new_note;
   logic [2:0]  r_voice_load, w_voice_load;
   logic [5:0]  r_note, w_note;
   logic [5:0]  r_dur, w_dur;
   logic [2:0]  r_meta, w_meta;
   logic        r_song_done, w_song_done;
   logic [5:0]  r_hold_note, w_hold_note;
   logic [5:0]  r_hold_dur, w_hold_dur;
   logic [2:0]  r_hold_meta, w_hold_meta;

   logic        w_is_adv;
   logic [5:0]  w_field;
   logic [5:0]  w_ent_dur;
   logic [2:0]  w_ent_meta;
   logic [2:0]  w_first_free;

   assign w_is_adv   = rom_data[15];
   assign w_field    = rom_data[14:9];
   assign w_ent_dur  = rom_data[8:3];
   assign w_ent_meta = rom_data[2:0];

   always_comb begin
      w_first_free = 3'b000;
      if (voice_free[0])      w_first_free = 3'b001;
      else if (voice_free[1]) w_first_free = 3'b010;
      else if (voice_free[2]) w_first_free = 3'b100;
   end

   // Every state change and counter update is gated by play, which freezes the walk.
   always_comb begin
      w_state      = r_state;
      w_index      = r_index;
      w_wait       = r_wait;
      w_song       = r_song;
      w_rom_addr   = r_rom_addr;
      w_new_note   = 1'b0;
      w_voice_load = '0;
      w_note       = r_note;
      w_dur        = r_dur;
      w_meta       = r_meta;
      w_song_done  = 1'b0;
      w_hold_note  = r_hold_note;
      w_hold_dur   = r_hold_dur;
      w_hold_meta  = r_hold_meta;

      case (r_state)
         S_IDLE: begin
            w_index = '0;
            w_song  = song_sel;
            if (play) begin
               w_state    = S_FETCH;
               w_rom_addr = {song_sel, 5'd0};
            end
         end
         S_FETCH: begin
            if (play) w_state = S_DECODE;
         end
         S_DECODE: begin
            if (play) begin
               w_hold_note = w_field;
               w_hold_dur  = w_ent_dur;
               w_hold_meta = w_ent_meta;
               if (!w_is_adv) begin
                  if (w_field == 6'd0) begin
                     w_state = S_NEXT;
                  end else if (|voice_free) begin
                     w_new_note   = 1'b1;
                     w_voice_load = w_first_free;
                     w_note       = w_field;
                     w_dur        = w_ent_dur;
                     w_meta       = w_ent_meta;
                     w_state      = S_NEXT;
                  end else begin
                     w_state = S_WAIT_VOICE;
                  end
               end else if (w_field == 6'd0) begin
                  w_state = S_NEXT;
               end else begin
                  w_wait  = w_field;
                  w_state = S_ADVANCE;
               end
            end
         end
         S_WAIT_VOICE: begin
            if (play && (|voice_free)) begin
               w_new_note   = 1'b1;
               w_voice_load = w_first_free;
               w_note       = r_hold_note;
               w_dur        = r_hold_dur;
               w_meta       = r_hold_meta;
               w_state      = S_NEXT;
            end
         end
         S_ADVANCE: begin
            if (play && beat) begin
               w_wait = r_wait - 6'd1;
               if (r_wait == 6'd1) w_state = S_NEXT;
            end
         end
         S_NEXT: begin
            if (play) begin
               if (r_index == 5'd31) begin
                  w_state     = S_DONE;
                  w_song_done = 1'b1;
               end else begin
                  w_index    = r_index + 5'd1;
                  w_rom_addr = {r_song, r_index + 5'd1};
                  w_state    = S_FETCH;
               end
            end
         end
         S_DONE: begin
            if (play) w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_index      <= '0;
         r_wait       <= '0;
         r_song       <= '0;
         r_rom_addr   <= '0;
         r_new_note   <= 1'b0;
         r_voice_load <= '0;
         r_note       <= '0;
         r_dur        <= '0;
         r_meta       <= '0;
         r_song_done  <= 1'b0;
         r_hold_note  <= '0;
         r_hold_dur   <= '0;
         r_hold_meta  <= '0;
      end else begin
         r_state      <= w_state;
         r_index      <= w_index;
         r_wait       <= w_wait;
         r_song       <= w_song;
         r_rom_addr   <= w_rom_addr;
         r_new_note   <= w_new_note;
         r_voice_load <= w_voice_load;
         r_note       <= w_note;
         r_dur        <= w_dur;
         r_meta       <= w_meta;
         r_song_done  <= w_song_done;
         r_hold_note  <= w_hold_note;
         r_hold_dur   <= w_hold_dur;
         r_hold_meta  <= w_hold_meta;
      end
   end

   assign rom_addr   = r_rom_addr;
   assign new_note   = r_new_note;
   assign voice_load = r_voice_load;
   assign note_out   = r_note;
   assign dur_out    = r_dur;
   assign meta_out   = r_meta;
   assign song_done  = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a ROM-walking reference model predicts address, load and
// end-of-song events; a negedge monitor matches them against what the DUT presents.
module tb_song_reader;

   logic        clk = 1'b0;
   logic        reset_n, play, beat;
   logic [1:0]  song_sel;
   logic [6:0]  rom_addr;
   logic [15:0] rom_data;
   logic [2:0]  voice_free;
   logic        new_note;
   logic [2:0]  voice_load;
   logic [5:0]  note_out, dur_out;
   logic [2:0]  meta_out;
   logic        song_done;

   always #5 clk = ~clk;

   song_reader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .play       (play),
      .song_sel   (song_sel),
      .beat       (beat),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .voice_free (voice_free),
      .new_note   (new_note),
      .voice_load (voice_load),
      .note_out   (note_out),
      .dur_out    (dur_out),
      .meta_out   (meta_out),
      .song_done  (song_done)
   );

   // Synchronous song ROM: data for the sampled address appears one cycle later.
   logic [15:0] rom [128];
   always @(posedge clk) rom_data <= rom[rom_addr];

   localparam int K_ADDR = 0;
   localparam int K_LOAD = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int         kind;
      logic [6:0] addr;
      logic [5:0] note;
      logic [5:0] dur;
      logic [2:0] meta;
      logic [2:0] voice;
   } ev_t;

   ev_t q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   bit  sb_en = 1'b0;

   function automatic string kname(input int k);
      case (k)
         K_ADDR:  return "addr";
         K_LOAD:  return "load";
         default: return "done";
      endcase
   endfunction

   function automatic logic [2:0] low_bit(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   // Expected event stream of one full song walk, derived straight from ROM contents.
   task automatic push_song(input int s, input bit skip0, input logic [2:0] vexp);
      ev_t         e;
      logic [15:0] w;
      for (int i = 0; i < 32; i++) begin
         w = rom[s*32 + i];
         e.addr = 7'(s*32 + i);
         e.note = '0; e.dur = '0; e.meta = '0; e.voice = '0;
         if (!(skip0 && i == 0)) begin
            e.kind = K_ADDR;
            q.push_back(e);
         end
         if (!w[15] && w[14:9] != 6'd0) begin
            e.kind  = K_LOAD;
            e.note  = w[14:9];
            e.dur   = w[8:3];
            e.meta  = w[2:0];
            e.voice = vexp;
            q.push_back(e);
         end
      end
      e.kind = K_DONE;
      e.addr = '0; e.note = '0; e.dur = '0; e.meta = '0; e.voice = '0;
      q.push_back(e);
   endtask

   task automatic sb_take(input int k);
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_err++;
         $display("FAIL sb_unexpected: got %s event, required none", kname(k));
         return;
      end
      e = q.pop_front();
      if (e.kind != k) begin
         n_err++;
         $display("FAIL sb_order: got %s event, required %s event (addr %0d)",
                  kname(k), kname(e.kind), e.addr);
      end else if (k == K_ADDR && rom_addr != e.addr) begin
         n_err++;
         $display("FAIL sb_addr: got %0d, required %0d", rom_addr, e.addr);
      end else if (k == K_LOAD && (note_out != e.note || dur_out != e.dur ||
                                   meta_out != e.meta || voice_load != e.voice)) begin
         n_err++;
         $display("FAIL sb_load: got note=%0d dur=%0d meta=%0d voice=%b, required note=%0d dur=%0d meta=%0d voice=%b",
                  note_out, dur_out, meta_out, voice_load, e.note, e.dur, e.meta, e.voice);
      end
   endtask

   initial begin : monitor
      logic [6:0] prev;
      prev = '0;
      forever begin
         @(negedge clk);
         if (sb_en) begin
            if (rom_addr != prev) sb_take(K_ADDR);
            if (new_note) sb_take(K_LOAD);
            else          check("voice_load_idle", int'(voice_load), 0);
            if (song_done) sb_take(K_DONE);
         end
         prev = rom_addr;
      end
   end

   task automatic fill_song(input int s, input bit all_notes);
      int          r;
      logic [15:0] w;
      for (int i = 0; i < 32; i++) begin
         r = all_notes ? 0 : int'($urandom_range(0, 9));
         w[8:3] = 6'($urandom_range(0, 63));
         w[2:0] = 3'($urandom_range(0, 7));
         if (r <= 5) begin
            w[15] = 1'b0; w[14:9] = 6'($urandom_range(1, 63));
         end else if (r == 6) begin
            w[15] = 1'b0; w[14:9] = 6'd0;
         end else if (r <= 8) begin
            w[15] = 1'b1; w[14:9] = 6'($urandom_range(1, 3));
         end else begin
            w[15] = 1'b1; w[14:9] = 6'd0;
         end
         rom[s*32 + i] = w;
      end
   endtask

   // Random beats, pauses and song_sel churn until every expected event has been seen.
   task automatic drain(input int budget, input int quiet);
      int cyc;
      cyc = 0;
      while (q.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         beat = ($urandom_range(0, 3) == 0);
         if (cyc > quiet) begin
            play     = ($urandom_range(0, 7) != 0);
            song_sel = 2'($urandom_range(0, 3));
         end
      end
      play = 1'b0;
      beat = 1'b0;
      check("drain_pending", q.size(), 0);
      q.delete();
   endtask

   task automatic wait_addr(input logic [6:0] target, input int budget);
      int c;
      c = 0;
      while (rom_addr != target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("wait_addr", int'(rom_addr), int'(target));
   endtask

   task automatic pulse_beat();
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rom_addr"},   int'(rom_addr),   0);
      check({tag, "_new_note"},   int'(new_note),   0);
      check({tag, "_voice_load"}, int'(voice_load), 0);
      check({tag, "_note_out"},   int'(note_out),   0);
      check({tag, "_dur_out"},    int'(dur_out),    0);
      check({tag, "_meta_out"},   int'(meta_out),   0);
      check({tag, "_song_done"},  int'(song_done),  0);
   endtask

   initial begin
      int s;
      reset_n    = 1'b0;
      play       = 1'b0;
      beat       = 1'b0;
      song_sel   = 2'd0;
      voice_free = 3'b000;
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;

      // First entry of song 0 is note 49, duration 12, all voices free.
      fill_song(0, 1'b0);
      rom[0]     = {1'b0, 6'd49, 6'd12, 3'd0};
      voice_free = 3'b111;
      push_song(0, 1'b1, low_bit(voice_free));
      sb_en    = 1'b1;
      song_sel = 2'd0;
      play     = 1'b1;
      drain(4000, 3);

      // Note entry stalls with no free voice, then only voice 2 frees up.
      fill_song(1, 1'b0);
      rom[32]    = {1'b0, 6'd17, 6'd5, 3'd3};
      voice_free = 3'b000;
      push_song(1, 1'b0, 3'b100);
      song_sel = 2'd1;
      play     = 1'b1;
      wait_addr(7'd32, 20);
      repeat (12) @(negedge clk);
      voice_free = 3'b100;
      drain(4000, 0);

      // Two advance entries of 12 beats: irregular gaps, then a pause mid-count.
      for (int i = 0; i < 32; i++) rom[96 + i] = {1'b0, 6'd0, 6'd3, 3'd1};
      rom[96]    = {1'b1, 6'd12, 6'd6, 3'd0};
      rom[97]    = {1'b1, 6'd12, 6'd6, 3'd0};
      voice_free = 3'b001;
      push_song(3, 1'b0, 3'b001);
      song_sel = 2'd3;
      play     = 1'b1;
      wait_addr(7'd96, 20);
      repeat (2) @(negedge clk);
      for (int b = 1; b <= 12; b++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         pulse_beat();
         check("adv_hold", int'(rom_addr), 96);
         if (b == 12) begin
            @(negedge clk);
            check("adv_fetch_after_12", int'(rom_addr), 97);
         end
      end
      repeat (2) @(negedge clk);
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         pulse_beat();
      end
      play = 1'b0;
      for (int b = 0; b < 20; b++) begin
         pulse_beat();
         @(negedge clk);
      end
      check("pause_hold", int'(rom_addr), 97);
      play = 1'b1;
      for (int b = 1; b <= 7; b++) begin
         @(negedge clk);
         pulse_beat();
         check("resume_hold", int'(rom_addr), 97);
         if (b == 7) begin
            @(negedge clk);
            check("resume_fetch_after_7", int'(rom_addr), 98);
         end
      end
      drain(2000, 0);

      for (int r = 0; r < 3; r++) begin
         s = int'($urandom_range(0, 3));
         fill_song(s, 1'b0);
         voice_free = 3'($urandom_range(1, 7));
         push_song(s, 1'b0, low_bit(voice_free));
         song_sel = 2'(s);
         play     = 1'b1;
         drain(5000, 3);
      end

      // Song 2, all notes: address walk 64..95, one song_done, no wrap to 96.
      fill_song(2, 1'b1);
      voice_free = 3'($urandom_range(1, 7));
      push_song(2, 1'b0, low_bit(voice_free));
      song_sel = 2'd2;
      play     = 1'b1;
      drain(5000, 3);
      repeat (10) @(negedge clk);
      check("end_addr", int'(rom_addr), 95);
      check("end_done_low", int'(song_done), 0);

      // Reset while stalled in the voice wait, then restart on the new song_sel.
      sb_en      = 1'b0;
      rom[0]     = {1'b0, 6'd5, 6'd2, 3'd1};
      voice_free = 3'b000;
      song_sel   = 2'd0;
      play       = 1'b1;
      repeat (10) @(negedge clk);
      check("stall_addr", int'(rom_addr), 0);
      check("stall_no_note", int'(new_note), 0);
      reset_n  = 1'b0;
      song_sel = 2'd3;
      @(negedge clk);
      check_all_zero("midreset");
      reset_n = 1'b1;
      @(negedge clk);
      check("restart_addr", int'(rom_addr), 96);
      check("restart_no_note", int'(new_note), 0);
      play = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
